// File: rtl/mux_out_fifo_if.sv
// mux_out_fifo_if: valid/ready handshake and status bundle between the mux, the buffer and its consumer
interface mux_out_fifo_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_data;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;
   logic [7:0]               force_cnt;
   logic                     ovf;
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, full, empty, force_cnt, ovf
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, full, empty, force_cnt, ovf
   );
endinterface

// File: rtl/mux_out_fifo.sv
// mux_out_fifo: FWFT buffer after the force-to-ones mux, counts all-ones words; MUX_OUT_FIFO_OVF_EN enables the sticky overflow flag
module mux_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   mux_out_fifo_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic [7:0]       fcnt;
   logic             full, empty, push, pop;
   assign full  = cnt == FULL_CNT;
   assign empty = cnt == '0;
   assign push  = bus.in_valid && !full;
   assign pop   = !empty && bus.out_ready;
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = cnt;
   assign bus.force_cnt = fcnt;
   assign bus.out_data  = empty ? '0 : mem[rd_ptr];
   // storage is not reset; it is hidden by the empty gate on out_data
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.in_data;
   // pointers and occupancy; count is kept apart from the pointers so full and empty are unambiguous
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         cnt    <= push && !pop ? cnt + 1'b1 : pop && !push ? cnt - 1'b1 : cnt;
      end
   // saturating tally of accepted all-ones words
   always_ff @(posedge clk)
      if (rst) fcnt <= '0;
      else if (push && bus.in_data == {WIDTH{1'b1}} && fcnt != 8'hFF) fcnt <= fcnt + 8'd1;
`ifdef MUX_OUT_FIFO_OVF_EN
   logic ovf;
   assign bus.ovf = ovf;
   // sticky flag for a word offered while the buffer refuses it
   always_ff @(posedge clk)
      if (rst) ovf <= 1'b0;
      else if (bus.in_valid && full) ovf <= 1'b1;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_mux_out_fifo.sv
// tb_mux_out_fifo: directed self-checking bench for mux_out_fifo
module tb_mux_out_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;
   logic exp_ovf;
   mux_out_fifo_if #(.DEPTH(4), .WIDTH(16)) bus ();
   mux_out_fifo #(.DEPTH(4), .WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_data = '0;
      step();
      rst = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got %b want 1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", bus.full); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
      total++; if (bus.force_cnt !== 8'd0) begin bad++; $display("FAIL reset_force_cnt got %0d want 0", bus.force_cnt); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
   endtask
   task automatic test_fill();
      logic [15:0] w [4] = '{16'h1234, 16'h0001, 16'hFFFF, 16'hABCD};
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = w[i];
         step();
         total++; if (bus.count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count got %0d want %0d", bus.count, i + 1); end
         total++; if (bus.out_data !== 16'h1234) begin bad++; $display("FAIL fill_head got %h want 1234", bus.out_data); end
      end
      bus.in_valid = 1'b0;
      total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got %b want 1", bus.full); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
      total++; if (bus.force_cnt !== 8'd1) begin bad++; $display("FAIL fill_force_cnt got %0d want 1", bus.force_cnt); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fill_out_valid got %b want 1", bus.out_valid); end
   endtask
   task automatic test_full_pop();
      logic [15:0] rest [3] = '{16'h0001, 16'hFFFF, 16'hABCD};
      bus.in_valid = 1'b1;
      bus.in_data = 16'h5555;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL fullpop_count got %0d want 3", bus.count); end
      total++; if (bus.out_data !== 16'h0001) begin bad++; $display("FAIL fullpop_head got %h want 0001", bus.out_data); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_in_ready got %b want 1", bus.in_ready); end
      total++; if (bus.ovf !== exp_ovf) begin bad++; $display("FAIL fullpop_ovf got %b want %b", bus.ovf, exp_ovf); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.out_data !== rest[i]) begin bad++; $display("FAIL drain_data got %h want %h", bus.out_data, rest[i]); end
         step();
      end
      bus.out_ready = 1'b0;
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got %b want 1", bus.empty); end
      total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL drain_out_data got %h want 0000", bus.out_data); end
      total++; if (bus.ovf !== exp_ovf) begin bad++; $display("FAIL drain_ovf_sticky got %b want %b", bus.ovf, exp_ovf); end
   endtask
   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            total++; if (bus.out_data !== 16'(16'h0100 + i - 1)) begin bad++; $display("FAIL stream_data got %h want %h", bus.out_data, 16'(16'h0100 + i - 1)); end
            total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL stream_count got %0d want 1", bus.count); end
         end
         bus.in_valid = 1'b1;
         bus.out_ready = 1'b1;
         bus.in_data = 16'(16'h0100 + i);
         step();
      end
      bus.in_valid = 1'b0;
      total++; if (bus.out_data !== 16'h0109) begin bad++; $display("FAIL stream_last got %h want 0109", bus.out_data); end
      step();
      bus.out_ready = 1'b0;
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL stream_empty got %b want 1", bus.empty); end
      total++; if (bus.force_cnt !== 8'd1) begin bad++; $display("FAIL stream_force_cnt got %0d want 1", bus.force_cnt); end
   endtask
   task automatic test_saturate();
      do_reset();
      bus.in_data = 16'hFFFF;
      for (int k = 1; k <= 300; k++) begin
         bus.in_valid = 1'b1;
         bus.out_ready = 1'b1;
         step();
         if (k == 100 || k == 254 || k == 255 || k == 300) begin
            total++; if (bus.force_cnt !== 8'(k > 255 ? 255 : k)) begin bad++; $display("FAIL sat_force_cnt at %0d got %0d want %0d", k, bus.force_cnt, k > 255 ? 255 : k); end
         end
      end
      bus.in_valid = 1'b0;
      step();
      bus.out_ready = 1'b0;
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL sat_empty got %b want 1", bus.empty); end
   endtask
   task automatic test_reset_mid();
      do_reset();
      bus.in_data = 16'hFFFF;
      bus.in_valid = 1'b1;
      repeat (3) step();
      total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL mid_fill_count got %0d want 3", bus.count); end
      total++; if (bus.force_cnt !== 8'd3) begin bad++; $display("FAIL mid_fill_force_cnt got %0d want 3", bus.force_cnt); end
      rst = 1'b1;
      bus.out_ready = 1'b1;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL mid_count got %0d want 0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_empty got %b want 1", bus.empty); end
      total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL mid_out_data got %h want 0000", bus.out_data); end
      total++; if (bus.force_cnt !== 8'd0) begin bad++; $display("FAIL mid_force_cnt got %0d want 0", bus.force_cnt); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf got %b want 0", bus.ovf); end
   endtask
   initial begin
`ifdef MUX_OUT_FIFO_OVF_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_data = '0;
      #1;
      test_reset();
      test_fill();
      test_full_pop();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
